alu_ctrl_sequencer: RTL and testbench

//  Control unit that drives the downsample datapath ALU: fetches 8-bit instructions from a

---
 rtl/alu_ctrl_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_ctrl_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_sequencer.sv
// Instruction sequencer for the downsample ALU; 3 cycles per ALU/NOP, 4 per jump, memory 3 + DDR wait.
// Backpressure: holds mem_rd/mem_wr until mem_ack with no timeout; start ignored while busy.
module alu_ctrl_sequencer #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [7:0]      imem_data,
    output logic [2:0]      alu_op,
    output logic [3:0]      a_sel,
    output logic            a_zero,
    output logic [3:0]      b_sel,
    output logic [3:0]      c_sel,
    output logic            c_we,
    input  logic            z,
    output logic            mem_rd,
    output logic            mem_wr,
    input  logic            mem_ack,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_EXEC, S_MWAIT, S_OPND, S_DONE
    } state_t;

    localparam logic [3:0] OPC_NOP   = 4'h0;
    localparam logic [3:0] OPC_STA   = 4'h9;
    localparam logic [3:0] OPC_LOAD  = 4'hA;
    localparam logic [3:0] OPC_STORE = 4'hB;
    localparam logic [3:0] OPC_JMP   = 4'hC;
    localparam logic [3:0] OPC_JNZ   = 4'hD;
    localparam logic [3:0] OPC_HALT  = 4'hE;
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc;
    logic [7:0]      ir;
    logic            err_q;
    logic            jmp_taken;

    logic [3:0] opc, rn, opc_m1;
    logic       is_alu, is_jump;

    assign opc     = ir[7:4];
    assign rn      = ir[3:0];
    assign opc_m1  = opc - 4'd1;
    assign is_alu  = (opc >= 4'd1) && (opc <= 4'd8);
    assign is_jump = (opc == OPC_JMP) || (opc == OPC_JNZ);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_FETCH;
            S_FETCH:        state_nxt = S_LATCH;
            S_LATCH:        state_nxt = S_EXEC;
            S_EXEC: begin
                if (opc == OPC_NOP || opc == OPC_STA || is_alu)
                    state_nxt = S_FETCH;
                else if (opc == OPC_LOAD || opc == OPC_STORE)
                    state_nxt = S_MWAIT;
                else if (is_jump)
                    state_nxt = S_OPND;
                else
                    state_nxt = S_DONE;
            end
            S_MWAIT:        if (mem_ack) state_nxt = S_FETCH;
            S_OPND:         state_nxt = S_FETCH;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // PC, IR, error and jump decision; the jump target byte arrives in OPND.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            ir        <= '0;
            err_q     <= 1'b0;
            jmp_taken <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pc    <= '0;
                        err_q <= 1'b0;
                    end
                end
                S_LATCH: begin
                    ir <= imem_data;
                    pc <= pc + PC_ONE;
                end
                S_EXEC: begin
                    if (opc == 4'hF) err_q <= 1'b1;
                    if (is_jump)     jmp_taken <= (opc == OPC_JMP) || !z;
                end
                S_OPND: pc <= jmp_taken ? PC_W'(imem_data) : pc + PC_ONE;
                default: ;
            endcase
        end
    end

    always_comb begin
        imem_addr = '0;
        alu_op    = '0;
        a_sel     = '0;
        a_zero    = 1'b0;
        b_sel     = '0;
        c_sel     = '0;
        c_we      = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        case (state)
            S_FETCH: imem_addr = pc;
            S_EXEC: begin
                if (is_alu) begin
                    alu_op = opc_m1[2:0];
                    a_sel  = rn;
                    c_we   = 1'b1;
                end else if (opc == OPC_STA) begin
                    a_zero = 1'b1;
                    c_sel  = rn;
                    c_we   = 1'b1;
                end else if (opc == OPC_LOAD) begin
                    mem_rd = 1'b1;
                end else if (opc == OPC_STORE) begin
                    mem_wr = 1'b1;
                end else if (is_jump) begin
                    imem_addr = pc;
                end
            end
            S_MWAIT: begin
                mem_rd = (opc == OPC_LOAD);
                mem_wr = (opc == OPC_STORE);
            end
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);
    assign err  = err_q;

    logic unused_ok;
    assign unused_ok = ^{OPC_HALT};

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Scoreboarded bench for alu_ctrl_sequencer: behavioural ROM, DDR responder and instruction decode model.
module tb_alu_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, z, mem_ack;
    logic [7:0] imem_data;
    logic [7:0] imem_addr;
    logic [2:0] alu_op;
    logic [3:0] a_sel, b_sel, c_sel;
    logic       a_zero, c_we, mem_rd, mem_wr, busy, done, err;

    logic [7:0]  rom [256];
    logic [17:0] sb_q [$];
    int          total = 0;
    int          bad   = 0;
    int          ack_dly = 5;
    bit          ack_en  = 1'b1;
    logic        spur_ack = 1'b0;
    logic        resp_ack = 1'b0;
    int          req_cnt  = 0;
    logic        prev_rd = 1'b0, prev_wr = 1'b0;

    assign mem_ack = resp_ack | spur_ack;

    alu_ctrl_sequencer #(.PC_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
        .alu_op(alu_op), .a_sel(a_sel), .a_zero(a_zero), .b_sel(b_sel), .c_sel(c_sel),
        .c_we(c_we), .z(z), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= rom[imem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] rec(input logic [1:0] kind, input logic [2:0] op,
                                        input logic [3:0] a, input logic az,
                                        input logic [3:0] b, input logic [3:0] c);
        return {kind, op, a, az, b, c};
    endfunction

    // Expected bus activity of one executed instruction.
    function automatic logic [17:0] model(input logic [7:0] instr);
        logic [3:0] opc, rn, m1;
        opc = instr[7:4];
        rn  = instr[3:0];
        m1  = opc - 4'd1;
        if (opc >= 4'd1 && opc <= 4'd8) return rec(2'd0, m1[2:0], rn, 1'b0, 4'd0, 4'd0);
        if (opc == 4'h9) return rec(2'd0, 3'd0, 4'd0, 1'b1, 4'd0, rn);
        if (opc == 4'hA) return rec(2'd1, 3'd0, 4'd0, 1'b0, 4'd0, 4'd0);
        if (opc == 4'hB) return rec(2'd2, 3'd0, 4'd0, 1'b0, 4'd0, 4'd0);
        return rec(2'd3, 3'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    endfunction

    task automatic expect_instr(input logic [7:0] instr);
        sb_q.push_back(model(instr));
    endtask

    task automatic sb_compare(input string tag, input logic [17:0] obs);
        if (sb_q.size() == 0) chk({tag, "_extra"}, sb_q.size(), 1);
        else                  chk(tag, obs, sb_q.pop_front());
    endtask

    // Output monitor plus DDR responder with programmable ack delay.
    always @(negedge clk) begin : mon
        logic [17:0] obs;
        chk("excl", (int'(c_we) + int'(mem_rd) + int'(mem_wr)) > 1, 0);
        if (c_we) sb_compare("alu", rec(2'd0, alu_op, a_sel, a_zero, b_sel, c_sel));
        else      chk("sel_idle", {alu_op, a_sel, a_zero, b_sel, c_sel}, 0);
        obs = rec(2'd0, alu_op, a_sel, a_zero, b_sel, c_sel);
        if (mem_rd && !prev_rd) sb_compare("rd", {2'd1, obs[15:0]});
        if (mem_wr && !prev_wr) sb_compare("wr", {2'd2, obs[15:0]});
        prev_rd = mem_rd;
        prev_wr = mem_wr;
        if (mem_rd || mem_wr) begin
            req_cnt++;
            resp_ack = ack_en && (req_cnt == ack_dly);
        end else begin
            if (req_cnt != 0 && ack_en) chk("mem_hold", req_cnt, ack_dly);
            req_cnt  = 0;
            resp_ack = 1'b0;
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'hE0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_to"}, done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; z = 1'b0;
        clear_rom();
        repeat (3) @(negedge clk);
        chk("reset_out", {imem_addr, alu_op, a_sel, a_zero, b_sel, c_sel, c_we,
                          mem_rd, mem_wr, busy, done, err}, 0);
        rst = 1'b0;

        // T1: ADD R3 then HALT, cycle-exact
        rom[0] = 8'h13; rom[1] = 8'hE0;
        expect_instr(8'h13);
        pulse_start();
        chk("t1_addr", imem_addr, 0);
        chk("t1_busy", busy, 1);
        @(negedge clk); chk("t1_cwe2", c_we, 0);
        @(negedge clk); chk("t1_cwe3", c_we, 1);
        chk("t1_op", {alu_op, a_sel, b_sel, c_sel}, {3'd0, 4'd3, 4'd0, 4'd0});
        repeat (3) @(negedge clk); chk("t1_done6", done, 0);
        @(negedge clk); chk("t1_done7", done, 1);
        chk("t1_busy_done", busy, 0);

        // T2: every ALU opcode, STA, NOP; start mid-run must be ignored
        clear_rom();
        for (int k = 0; k < 8; k++) begin
            rom[k] = {4'(k + 1), 4'((k * 3 + 1) % 16)};
            expect_instr(rom[k]);
        end
        rom[8] = 8'h95; rom[9] = 8'h00;
        expect_instr(8'h95);
        pulse_start();
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done("t2", 200);

        // T3: LOAD/STORE with delayed ack, spurious ack in FETCH, start during MWAIT
        clear_rom();
        rom[0] = 8'hA0; rom[1] = 8'h11; rom[2] = 8'hB0;
        expect_instr(8'hA0); expect_instr(8'h11); expect_instr(8'hB0);
        ack_dly = 5;
        pulse_start();
        spur_ack = 1'b1;
        @(negedge clk) spur_ack = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done("t3", 200);

        // T4: JNZ taken / not taken, JMP to 0xFF and PC wrap
        for (int pass = 0; pass < 2; pass++) begin
            clear_rom();
            rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44;
            rom[4] = 8'hD0; rom[5] = 8'h20; rom[8'h20] = 8'h55; rom[6] = 8'h66;
            for (int k = 0; k < 4; k++) expect_instr(rom[k]);
            expect_instr(pass == 0 ? 8'h55 : 8'h66);
            z = (pass == 1);
            pulse_start();
            wait_done("t4_jnz", 200);
        end
        clear_rom();
        rom[0] = 8'hD0; rom[1] = 8'h10; rom[2] = 8'hE0;
        rom[8'h10] = 8'hC0; rom[8'h11] = 8'hFF; rom[8'hFF] = 8'h27;
        expect_instr(8'h27);
        z = 1'b0;
        pulse_start();
        begin
            int n = 0;
            while (!c_we && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("t4_wrap_op_seen", c_we, 1);
        end
        z = 1'b1;
        wait_done("t4_wrap", 200);

        // T5: illegal opcode sets err; restart clears it
        clear_rom();
        rom[0] = 8'hF0;
        pulse_start();
        wait_done("t5", 50);
        chk("t5_err", err, 1);
        rom[0] = 8'h31;
        expect_instr(8'h31);
        pulse_start();
        chk("t5_err_clr", err, 0);
        chk("t5_addr", imem_addr, 0);
        wait_done("t5b", 50);

        // T6: reset while waiting for DDR
        clear_rom();
        rom[0] = 8'hA0;
        expect_instr(8'hA0);
        ack_en = 1'b0;
        pulse_start();
        begin
            int n = 0;
            while (!mem_rd && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("t6_req", mem_rd, 1);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_out", {imem_addr, alu_op, a_sel, a_zero, b_sel, c_sel, c_we,
                       mem_rd, mem_wr, busy, done, err}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_idle", {busy, done, mem_rd}, 0);
        ack_en = 1'b1;

        chk("sb_left", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
